onehot_scanner: RTL and testbench

//   Parametrised one-hot position scanner: a single active bit walks across WIDTH outputs,

---
 rtl/onehot_scanner_pkg.sv | 24 ++
 rtl/onehot_scanner_prescaler.sv | 34 +++
 rtl/onehot_scanner.sv | 165 ++++++++++++++++
 tb/tb_onehot_scanner.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/onehot_scanner_pkg.sv
// Shared definitions for the one-hot position scanner.
//   mode_e    : sweep mode encodings as seen on the 2-bit mode port
//   state_e   : scanner state (IDLE = all-zero output, RUN = one bit set)
//   clamp_pos : saturates a requested load position to the last valid index
package onehot_scanner_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_BOUNCE  = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_HOLD    = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Positions at or beyond the vector width land on the last bit.
  function automatic int unsigned clamp_pos(input int unsigned p, input int unsigned width);
    return (p >= width) ? (width - 1) : p;
  endfunction

endpackage

// File: rtl/onehot_scanner_prescaler.sv
// tick_prescaler: divides enabled cycles down to a single-cycle tick.
//   clk, rst : clock and asynchronous active-low reset
//   en       : counter advances only while high
//   clr      : synchronous counter clear (used on load)
//   div      : tick every div+1 enabled cycles
//   tick_c   : combinational tick, high in the cycle the count matches div
module tick_prescaler #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick_c
);

  logic [DIV_W-1:0] cnt;

  // Compared against the live div value so rate changes apply immediately.
  assign tick_c = en && (cnt == div);

  // If div drops below cnt the counter runs on through its natural wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr || tick_c) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/onehot_scanner.sv
// onehot_scanner: a single active bit walks across WIDTH outputs, one place per
// prescaled tick, in WRAP, BOUNCE, ONESHOT or HOLD mode.
//   clk, rst : clock and asynchronous active-low reset
//   en       : prescaler enable (0 freezes count and output)
//   dir      : 1 = toward MSB, 0 = toward LSB
//   mode     : 00 WRAP, 01 BOUNCE, 10 ONESHOT, 11 HOLD
//   div      : tick every div+1 enabled cycles
//   load     : synchronous load of load_pos (clamped to WIDTH-1)
//   out      : one-hot position, all-zero when idle
//   pos      : binary index of the active bit (0 when idle)
//   step     : pulse in the cycle out advances
//   wrap     : pulse in the cycle a sweep end is handled
// Build option SCANNER_BLANK_EN: a WRAP end-tick blanks out for one tick
// period before the start bit reappears (sweep period WIDTH+1 ticks).
module onehot_scanner
  import onehot_scanner_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DIV_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     dir,
  input  logic [1:0]               mode,
  input  logic [DIV_W-1:0]         div,
  input  logic                     load,
  input  logic [$clog2(WIDTH)-1:0] load_pos,
  output logic [WIDTH-1:0]         out,
  output logic [$clog2(WIDTH)-1:0] pos,
  output logic                     step,
  output logic                     wrap
);

  localparam int unsigned POS_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] LSB_BIT = WIDTH'(1);
  localparam logic [WIDTH-1:0] MSB_BIT = LSB_BIT << (WIDTH - 1);

  state_e           state_q;
  state_e           state_d;
  logic             dir_q;
  logic             dir_d;
  logic [WIDTH-1:0] out_d;
  logic [POS_W-1:0] pos_d;
  logic             step_d;
  logic             wrap_d;
  logic             tick_c;
  logic             at_end_c;
  logic [POS_W-1:0] load_idx_c;
  mode_e            mode_c;

  tick_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .clr    (load),
    .div    (div),
    .tick_c (tick_c)
  );

  assign mode_c     = mode_e'(mode);
  assign load_idx_c = POS_W'(clamp_pos(32'(load_pos), WIDTH));
  // End of sweep depends on the latched direction, not the live dir input.
  assign at_end_c   = dir_q ? out[WIDTH-1] : out[0];

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, next output vector and event pulses; load beats tick.
  always_comb begin
    state_d = state_q;
    out_d   = out;
    dir_d   = dir_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;

    if (load) begin
      out_d   = LSB_BIT << load_idx_c;
      dir_d   = dir;
      state_d = ST_RUN;
    end else if (tick_c && (mode_c != MODE_HOLD)) begin
      case (state_q)
        ST_IDLE: begin
          // ONESHOT stays parked until an explicit load.
          if (mode_c != MODE_ONESHOT) begin
            out_d   = dir ? LSB_BIT : MSB_BIT;
            dir_d   = dir;
            state_d = ST_RUN;
            step_d  = 1'b1;
          end
        end
        ST_RUN: begin
          step_d = 1'b1;
          // BOUNCE owns its direction; other modes pick up dir for the next tick.
          if (mode_c != MODE_BOUNCE) begin
            dir_d = dir;
          end
          if (!at_end_c) begin
            out_d = dir_q ? (out << 1) : (out >> 1);
          end else begin
            wrap_d = 1'b1;
            case (mode_c)
              MODE_BOUNCE: begin
                dir_d = ~dir_q;
                out_d = dir_q ? (out >> 1) : (out << 1);
              end
              MODE_ONESHOT: begin
                out_d   = '0;
                state_d = ST_IDLE;
              end
              MODE_WRAP: begin
`ifdef SCANNER_BLANK_EN
                out_d   = '0;
                state_d = ST_IDLE;
`else
                out_d   = dir_q ? LSB_BIT : MSB_BIT;
`endif
              end
              default: begin
              end
            endcase
          end
        end
        default: begin
        end
      endcase
    end
  end

  // One-hot to binary encoder on the next output vector.
  always_comb begin
    pos_d = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (out_d[i]) begin
        pos_d = POS_W'(i);
      end
    end
  end

  // Output and direction registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out   <= '0;
      pos   <= '0;
      step  <= 1'b0;
      wrap  <= 1'b0;
      dir_q <= 1'b0;
    end else begin
      out   <= out_d;
      pos   <= pos_d;
      step  <= step_d;
      wrap  <= wrap_d;
      dir_q <= dir_d;
    end
  end

endmodule

// File: tb/tb_onehot_scanner.sv
// Self-checking bench for onehot_scanner: three widths (4, 5, 8) share one
// stimulus stream; a position/direction model is compared every cycle, and
// directed scenarios pin literal values.
module tb_onehot_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en, dir, load;
  logic [1:0] mode;
  logic [7:0] div;
  logic [2:0] lp;

  logic [3:0] out4;
  logic [1:0] pos4;
  logic       step4, wrap4;
  logic [4:0] out5;
  logic [2:0] pos5;
  logic       step5, wrap5;
  logic [7:0] out8;
  logic [2:0] pos8;
  logic       step8, wrap8;

  int checks = 0;
  int errors = 0;

`ifdef SCANNER_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  onehot_scanner #(.WIDTH(4), .DIV_W(8)) u4 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .div(div),
    .load(load), .load_pos(lp[1:0]), .out(out4), .pos(pos4), .step(step4), .wrap(wrap4));
  onehot_scanner #(.WIDTH(5), .DIV_W(8)) u5 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .div(div),
    .load(load), .load_pos(lp), .out(out5), .pos(pos5), .step(step5), .wrap(wrap5));
  onehot_scanner #(.WIDTH(8), .DIV_W(8)) u8 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .div(div),
    .load(load), .load_pos(lp), .out(out8), .pos(pos8), .step(step8), .wrap(wrap8));

  always #5 clk = ~clk;

  // Model: position as an integer (-1 = idle), direction, shared tick counter.
  int mp[3] = '{-1, -1, -1};
  int md[3] = '{0, 0, 0};
  int ms[3] = '{0, 0, 0};
  int mw[3] = '{0, 0, 0};
  int mcnt  = 0;

  function automatic int wof(input int i);
    return (i == 0) ? 4 : ((i == 1) ? 5 : 8);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcnt <= 0;
      for (int i = 0; i < 3; i++) begin
        mp[i] <= -1; md[i] <= 0; ms[i] <= 0; mw[i] <= 0;
      end
    end else begin
      bit tk;
      tk = en && (mcnt == int'(div));
      for (int i = 0; i < 3; i++) begin
        int p, d, s, wr, w, lpm;
        w = wof(i); p = mp[i]; d = md[i]; s = 0; wr = 0;
        lpm = (i == 0) ? int'(lp[1:0]) : int'(lp);
        if (load) begin
          p = (lpm > w - 1) ? w - 1 : lpm;
          d = int'(dir);
        end else if (tk && mode != 2'd3) begin
          if (p < 0) begin
            if (mode != 2'd2) begin
              p = dir ? 0 : w - 1; d = int'(dir); s = 1;
            end
          end else begin
            s = 1;
            if ((d == 1 && p == w - 1) || (d == 0 && p == 0)) begin
              wr = 1;
              if (mode == 2'd1) begin
                d = 1 - d; p = (d == 1) ? p + 1 : p - 1;
              end else if (mode == 2'd2) begin
                p = -1; d = int'(dir);
              end else begin
                p = BLANK ? -1 : ((d == 1) ? 0 : w - 1); d = int'(dir);
              end
            end else begin
              p = (d == 1) ? p + 1 : p - 1;
              if (mode != 2'd1) d = int'(dir);
            end
          end
        end
        mp[i] <= p; md[i] <= d; ms[i] <= s; mw[i] <= wr;
      end
      if (load || tk) mcnt <= 0;
      else if (en) mcnt <= (mcnt + 1) % 256;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int act_out(input int i);
    return (i == 0) ? int'(out4) : ((i == 1) ? int'(out5) : int'(out8));
  endfunction
  function automatic int act_pos(input int i);
    return (i == 0) ? int'(pos4) : ((i == 1) ? int'(pos5) : int'(pos8));
  endfunction
  function automatic int act_step(input int i);
    return (i == 0) ? int'(step4) : ((i == 1) ? int'(step5) : int'(step8));
  endfunction
  function automatic int act_wrap(input int i);
    return (i == 0) ? int'(wrap4) : ((i == 1) ? int'(wrap5) : int'(wrap8));
  endfunction

  // Every-cycle comparison against the model.
  always begin
    @(negedge clk);
    #2;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("w%0d_out", wof(i)), act_out(i), (mp[i] < 0) ? 0 : (1 << mp[i]));
      chk($sformatf("w%0d_pos", wof(i)), act_pos(i), (mp[i] < 0) ? 0 : mp[i]);
      chk($sformatf("w%0d_step", wof(i)), act_step(i), ms[i]);
      chk($sformatf("w%0d_wrap", wof(i)), act_wrap(i), mw[i]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  int s3o[7] = '{2, 4, 8, 4, 2, 1, 2};
  int s3w[7] = '{0, 0, 0, 1, 0, 0, 1};
  int s4o[4] = '{4, 2, 1, 0};

  initial begin
    en = 1'b0; dir = 1'b0; load = 1'b0; mode = 2'd0; div = 8'd0; lp = 3'd0;
    rst = 1'b0;
    repeat (2) cyc();
    chk("rst_out", int'(out4), 0);
    chk("rst_pos", int'(pos4), 0);
    chk("rst_step", int'(step4), 0);

    // Scenario 1: WRAP upward sweep from idle.
    en = 1'b1; dir = 1'b1; mode = 2'd0; div = 8'd0; rst = 1'b1;
    cyc(); chk("s1_out0", int'(out4), 1); chk("s1_step", int'(step4), 1);
    cyc(); chk("s1_out1", int'(out4), 2);
    cyc(); chk("s1_out2", int'(out4), 4);
    cyc(); chk("s1_out3", int'(out4), 8); chk("s1_nowrap", int'(wrap4), 0);
    cyc();
`ifdef SCANNER_BLANK_EN
    chk("s1_blank", int'(out4), 0); chk("s1_wrap", int'(wrap4), 1);
    cyc(); chk("s1_restart", int'(out4), 1);
`else
    chk("s1_jump", int'(out4), 1); chk("s1_wrap", int'(wrap4), 1);
`endif

    // Scenario 2: div=3 with an enable gap mid-count.
    div = 8'd3; load = 1'b1; lp = 3'd0;
    cyc(); load = 1'b0; chk("s2_load", int'(out4), 1);
    repeat (3) cyc(); chk("s2_wait", int'(out4), 1);
    cyc(); chk("s2_tick", int'(out4), 2);
    repeat (2) cyc();
    en = 1'b0; repeat (5) cyc(); chk("s2_frozen", int'(out4), 2);
    en = 1'b1;
    cyc(); chk("s2_resume", int'(out4), 2);
    cyc(); chk("s2_tick2", int'(out4), 4);

    // Scenario 3: BOUNCE from 0001, dir input flipped after load to show it is ignored.
    div = 8'd0; mode = 2'd1; dir = 1'b1; load = 1'b1; lp = 3'd0;
    cyc(); load = 1'b0; dir = 1'b0; chk("s3_load", int'(out4), 1);
    for (int k = 0; k < 7; k++) begin
      cyc();
      chk($sformatf("s3_out%0d", k), int'(out4), s3o[k]);
      chk($sformatf("s3_wrap%0d", k), int'(wrap4), s3w[k]);
    end

    // Scenario 4: ONESHOT downward, then parked until load.
    mode = 2'd2; dir = 1'b0; load = 1'b1; lp = 3'd3;
    cyc(); load = 1'b0; chk("s4_load", int'(out4), 8);
    for (int k = 0; k < 4; k++) begin
      cyc(); chk($sformatf("s4_out%0d", k), int'(out4), s4o[k]);
    end
    chk("s4_wrap", int'(wrap4), 1);
    repeat (20) cyc();
    chk("s4_parked", int'(out4), 0); chk("s4_nostep", int'(step4), 0);
    load = 1'b1; lp = 3'd2;
    cyc(); load = 1'b0; chk("s4_reload", int'(out4), 4);

    // Scenario 5: load coinciding with a tick, out-of-range position.
    mode = 2'd0; dir = 1'b0; load = 1'b1; lp = 3'd7;
    cyc(); load = 1'b0; div = 8'd2;
    chk("s5_out4", int'(out4), 8); chk("s5_step", int'(step4), 0);
    chk("s5_out5", int'(out5), 16); chk("s5_pos5", int'(pos5), 4);
    chk("s5_out8", int'(out8), 128);
    repeat (2) cyc(); chk("s5_cnt_hold", int'(out4), 8);
    cyc(); chk("s5_cnt_tick", int'(out4), 4);

    // Scenario 6: asynchronous reset mid-sweep, then WIDTH=8 sweep.
    div = 8'd0; dir = 1'b1; load = 1'b1; lp = 3'd0;
    cyc(); load = 1'b0;
    repeat (2) cyc(); chk("s6_pre", int'(out4), 4);
    rst = 1'b0; #1;
    chk("s6_async_out", int'(out4), 0); chk("s6_async_pos", int'(pos4), 0);
    chk("s6_async_out8", int'(out8), 0);
    cyc(); rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk($sformatf("s6_pos8_%0d", k), int'(pos8), k);
      chk($sformatf("s6_out8_%0d", k), int'(out8), 1 << k);
    end

    // Randomized traffic, model-checked every cycle.
    for (int n = 0; n < 3000; n++) begin
      cyc();
      rst  = ($urandom_range(0, 399) != 0);
      en   = ($urandom_range(0, 9) != 0);
      load = ($urandom_range(0, 19) == 0);
      lp   = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) dir = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 24) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) div = 8'($urandom_range(0, 3));
    end
    rst = 1'b1; load = 1'b0;
    repeat (2) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
